// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding and small helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud.sv
// Baud oversample generator: one tick every cfg_div_i+1 clocks, plus a 4-bit
// tick phase within the current bit (16 ticks per bit). clear_i restarts both.
module uart_baud (
  input  logic        clk_i,
  input  logic        rst_b_i,
  input  logic        clear_i,
  input  logic [15:0] cfg_div_i,
  output logic        tick_o,
  output logic [3:0]  phase_o
);

  logic [15:0] pre_q, pre_d;
  logic [3:0]  phase_q, phase_d;

  assign tick_o  = (pre_q == 16'd0) & ~clear_i;
  assign phase_o = phase_q;

  always_comb begin
    pre_d   = pre_q - 16'd1;
    phase_d = phase_q;
    if (clear_i) begin
      pre_d   = cfg_div_i;
      phase_d = 4'd0;
    end else if (tick_o) begin
      pre_d   = cfg_div_i;
      phase_d = phase_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      pre_q   <= 16'd0;
      phase_q <= 4'd0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, 1 or 2 stop bits, single holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_div,
  input  logic        cfg_rxen,
  input  logic        cfg_nstop,
  input  logic        uart_rxd,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_ferr,
  input  logic        rx_ready,
  output logic        rx_overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s, rxd_prev_q;
  uart_state_e            state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic                   valid_q, valid_d, ferr_q, ferr_d, overrun_q, overrun_d;
  logic [7:0]             data_q, data_d;
  logic                   baud_clear, baud_tick, complete;
  logic [3:0]             baud_phase;
  logic                   baud_sample_8th, baud_sample_16th, sample_pt, bit_val;

  assign rxd_s = sync_q[SYNC_STAGES-1];

  uart_baud u_baud (
    .clk_i     (clk),
    .rst_b_i   (~rst),
    .clear_i   (baud_clear),
    .cfg_div_i (cfg_div),
    .tick_o    (baud_tick),
    .phase_o   (baud_phase)
  );

  // phase counts ticks already taken in this bit, so the Nth tick sees N-1
  assign baud_sample_8th  = baud_tick & (baud_phase == 4'd7);
  assign baud_sample_16th = baud_tick & (baud_phase == 4'd15);

`ifdef UART_RX_MAJORITY_EN
  logic baud_sample_6th, baud_sample_10th, maj6_q, maj8_q;
  assign baud_sample_6th  = baud_tick & (baud_phase == 4'd5);
  assign baud_sample_10th = baud_tick & (baud_phase == 4'd9);
  assign sample_pt        = baud_sample_10th;
  assign bit_val          = maj3(maj6_q, maj8_q, rxd_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      maj6_q <= 1'b1;
      maj8_q <= 1'b1;
    end else begin
      if (baud_sample_6th) maj6_q <= rxd_s;
      if (baud_sample_8th) maj8_q <= rxd_s;
    end
  end
`else
  assign sample_pt = baud_sample_8th;
  assign bit_val   = rxd_s;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
    baud_clear = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_rxen && rxd_prev_q && !rxd_s) begin
          baud_clear = 1'b1;
          state_d    = ST_START;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      ST_START: begin
        if (sample_pt && bit_val) state_d = ST_IDLE;
        else if (baud_sample_16th) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sample_pt) shift_d = {bit_val, shift_q[7:1]};
        if (baud_sample_16th) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_pt) begin
          ferr_acc_d = ferr_acc_q | ~bit_val;
          if (!cfg_nstop || stop_cnt_q) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (baud_sample_16th) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // disabling the receiver abandons any partial frame
    if (!cfg_rxen) begin
      state_d  = ST_IDLE;
      complete = 1'b0;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;
    if (complete) begin
      if (!valid_q || rx_ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        ferr_d  = ferr_acc_d;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'h00;
      ferr_acc_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
      rxd_prev_q <= rxd_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_valid   = valid_q;
  assign rx_data    = data_q;
  assign rx_ferr    = ferr_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames driven bit by bit at cfg_div=3,
// expected bytes queued on send and compared when rx_valid is seen.
module tb_uart_rx;

  localparam int DIV = 3;
  localparam int BIT = 16 * (DIV + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int STOP_LAT = 43;
`else
  localparam int STOP_LAT = 35;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = 16'(DIV);
  logic        cfg_rxen = 1'b1;
  logic        cfg_nstop = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ferr;
  logic        rx_ready = 1'b0;
  logic        rx_overrun;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          ovr_cnt = 0;
  logic [8:0]  exp_q[$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div    (cfg_div),
    .cfg_rxen   (cfg_rxen),
    .cfg_nstop  (cfg_nstop),
    .uart_rxd   (uart_rxd),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ferr    (rx_ferr),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

  // all line drivers start and end on a falling clock edge
  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop1, input logic stop2,
                            input logic two, input int idle_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop1);
    if (two) drive_bit(stop2);
    uart_rxd = 1'b1;
    repeat (idle_bits * BIT) @(negedge clk);
  endtask

  task automatic check_rx(input string name);
    int c = 0;
    logic [8:0] e;
    while (rx_valid !== 1'b1 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: rx_valid=%b required 1", name, rx_valid);
      return;
    end
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: got data=%h with no byte expected", name, rx_data);
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (rx_data !== e[7:0]) begin
      n_fail++;
      $display("FAIL %s_data: got %h required %h", name, rx_data, e[7:0]);
    end
    n_cmp++;
    if (rx_ferr !== e[8]) begin
      n_fail++;
      $display("FAIL %s_ferr: got %b required %b", name, rx_ferr, e[8]);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_valid_drop: got %b required 0", name, rx_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({rx_valid, rx_ferr, rx_overrun, rx_data} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b f=%b o=%b d=%h required all 0",
               rx_valid, rx_ferr, rx_overrun, rx_data);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic();
    int c = 0;
    logic [7:0] b = 8'hA5;
    exp_q.push_back({1'b0, 8'hA5});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    uart_rxd = 1'b1;
    while (rx_valid !== 1'b1 && c < BIT) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c != STOP_LAT) begin
      n_fail++;
      $display("FAIL basic_latency: rx_valid after %0d cycles of stop bit, required %0d", c, STOP_LAT);
    end
    repeat (BIT - c + BIT) @(negedge clk);
    check_rx("basic_a5");
  endtask

  task automatic test_frame_error();
    exp_q.push_back({1'b1, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 2);
    check_rx("ferr_3c");
  endtask

  task automatic test_glitch();
    uart_rxd = 1'b0;
    repeat (4 * (DIV + 1)) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_no_valid: got %b required 0", rx_valid);
    end
    exp_q.push_back({1'b0, 8'hC3});
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 2);
    check_rx("glitch_then_c3");
  endtask

  task automatic test_back_to_back();
    int ovr_base;
    rx_ready = 1'b0;
    ovr_base = ovr_cnt;
    exp_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 2);
    n_cmp++;
    if (ovr_cnt - ovr_base != 1) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %0d pulses required 1", ovr_cnt - ovr_base);
    end
    check_rx("b2b_11");
    repeat (BIT) @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_dropped: rx_valid=%b required 0", rx_valid);
    end
  endtask

  task automatic test_two_stop();
    cfg_nstop = 1'b1;
    exp_q.push_back({1'b1, 8'h96});
    send_frame(8'h96, 1'b1, 1'b0, 1'b1, 2);
    check_rx("nstop2_bad");
    exp_q.push_back({1'b0, 8'h69});
    send_frame(8'h69, 1'b1, 1'b1, 1'b1, 2);
    check_rx("nstop2_good");
    cfg_nstop = 1'b0;
  endtask

  task automatic test_rxen_drop();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    cfg_rxen = 1'b0;
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    cfg_rxen = 1'b1;
    repeat (BIT) @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rxen_partial: rx_valid=%b required 0", rx_valid);
    end
    exp_q.push_back({1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 2);
    check_rx("rxen_5a");
    repeat (2 * BIT) @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rxen_single: rx_valid=%b required 0", rx_valid);
    end
  endtask

  task automatic test_reset_midframe();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rst = 1'b1;
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: rx_valid=%b required 0", rx_valid);
    end
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 2);
    check_rx("after_reset_81");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_two_stop();
    test_rxen_drop();
    test_reset_midframe();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d bytes never received, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops in the uart_rxd synchronizer (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_div  input  16  baud divider, with the same meaning as for the transmit path.
REQ-005 SHALL have port cfg_rxen  input  1  receive enable.
REQ-006 SHALL have port cfg_nstop  input  1  stop-bit count select: 0 = one stop bit, 1 = two stop bits.
REQ-007 SHALL have port uart_rxd  input  1  asynchronous serial line; idles high.
REQ-008 SHALL have port rx_valid  output  1  a received byte is held.
REQ-009 SHALL have port rx_data  output  8  the received byte; LSb is the first bit received.
REQ-010 SHALL have port rx_ferr  output  1  frame error flag for the held byte; valid only while rx_valid = 1.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts the byte when rx_valid and rx_ready are both 1.
REQ-012 SHALL have port rx_overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-013 SHALL pass uart_rxd through a SYNC_STAGES flop synchronizer, with every stage reset to 1; all other logic uses only the synchronized value.
REQ-014 SHALL implement the states IDLE, START, DATA and STOP.
REQ-015 IDLE: on a synchronized 1->0 transition with cfg_rxen = 1, SHALL pulse the baud clear for one cycle and enter START.
REQ-016 START: at the sample point, if the sampled value is 1 (false start), SHALL return to IDLE; otherwise SHALL enter DATA at baud_sample_16th.
REQ-017 DATA: SHALL shift each sampled bit into bit 7 of an 8-bit shift register (shift right) at the sample point, increment a 3-bit counter at baud_sample_16th, and enter STOP at baud_sample_16th when the count is 7.
REQ-018 STOP: SHALL sample each stop bit and OR (sampled == 0) into a frame error accumulator; completion occurs at the last stop bit's sample point.
REQ-019 With cfg_nstop = 1, SHALL sample the first stop bit, wait for its baud_sample_16th, then sample the second stop bit, which is the completion point.
REQ-020 On completion, SHALL return to IDLE on the same edge, so that a back-to-back start edge is not missed.
REQ-021 Output latency: rx_valid, rx_data and rx_ferr SHALL update in the cycle after the completion sample.
REQ-022 Completion with rx_valid = 0, or with rx_valid = 1 and rx_ready = 1 in the same cycle, SHALL load the holding register and keep or raise rx_valid.
REQ-023 Completion with rx_valid = 1 and rx_ready = 0 SHALL keep the old byte, drop the new byte, and pulse rx_overrun for 1 cycle.
REQ-024 rx_valid SHALL fall in the cycle after a handshake when there is no simultaneous completion.
REQ-025 rx_data and rx_ferr SHALL stay stable while rx_valid = 1 and rx_ready = 0.
REQ-026 Deasserting cfg_rxen mid-frame SHALL force IDLE on the next edge and discard the partial byte; the holding register is unaffected.
REQ-027 A frame with a frame error SHALL still be delivered, with rx_ferr = 1.

Reset
REQ-028 Reset SHALL set the state to IDLE and clear the data counter, stop counter, shift register and frame error accumulator.
REQ-029 Reset SHALL set rx_valid, rx_ferr and rx_overrun to 0, set rx_data to 8'h00, and set the synchronizer stages to 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame, and no rx_valid SHALL follow.

Configuration
REQ-031 With UART_RX_MAJORITY_EN defined, the bit value SHALL be the 2-of-3 majority of samples taken at baud_sample_6th, baud_sample_8th and baud_sample_10th; the sample point is baud_sample_10th.
REQ-032 Without UART_RX_MAJORITY_EN, the bit value SHALL be the single sample taken at baud_sample_8th, which is also the sample point.

Structure
REQ-033 State encodings (IDLE=0, START=1, DATA=2, STOP=3) SHALL live in a shared package uart_pkg, which the transmit path also uses.
REQ-034 The block SHALL instantiate the existing uart_baud as its only sub-module, with clear = the start-edge pulse and its rst_b driven by ~rst.
REQ-035 The block SHALL contain no other sub-modules.

Verification
REQ-036 Byte 8'hA5, cfg_nstop=0, cfg_div=3, valid stop bit -> rx_valid=1, rx_data=8'hA5, rx_ferr=0, one cycle after the stop sample.
REQ-037 Byte 8'h3C with its stop bit driven 0 -> rx_data=8'h3C, rx_ferr=1.
REQ-038 Low glitch of 4 oversample ticks on an idle line -> returns to IDLE and rx_valid stays 0.
REQ-039 Bytes 8'h11 then 8'h22 back-to-back with rx_ready=0 -> rx_data stays 8'h11 and rx_overrun pulses once; after rx_ready=1 for one cycle -> rx_valid=0.
REQ-040 cfg_nstop=1 with the second stop bit 0 -> rx_ferr=1; with both stop bits 1 -> rx_ferr=0.
REQ-041 cfg_rxen dropped after 3 data bits, then byte 8'h5A sent with cfg_rxen=1 -> a single rx_valid with rx_data=8'h5A.
